// File: rtl/fifo_pop_agent.sv
// fifo_pop_agent: drains a FIFO through a pop_req/pop_ack handshake and
// forwards each word downstream through a 2-entry valid/ready buffer.
// A watchdog flags requests left unacknowledged for too long.
module fifo_pop_agent #(
  parameter int WIDTH       = 8,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  output logic             pop_req,
  input  logic             pop_ack,
  input  logic [WIDTH-1:0] data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] pop_count,
  output logic             stall_err,
  output logic             busy
);

  localparam int WAIT_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_pop_req;
  logic [WIDTH-1:0]   r_buf [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_buf_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_stall_err;
  logic [CNT_W-1:0]   r_pop_count;
  logic               w_pop_hsk;
  logic               w_buf_wr;
  logic               w_buf_rd;
  logic               w_enter_req;

  assign w_pop_hsk   = r_pop_req && pop_ack;
  assign w_buf_wr    = (r_state == ST_CAPT);
  assign w_buf_rd    = m_valid && m_ready;
  assign w_enter_req = (r_state != ST_REQ) && (w_state_nxt == ST_REQ);

  assign pop_req   = r_pop_req;
  assign m_valid   = (r_buf_cnt != 2'd0);
  // Gate the head with valid so stale storage never shows after reset.
  assign m_data    = m_valid ? r_buf[r_rd_ptr] : '0;
  assign pop_count = r_pop_count;
  assign stall_err = r_stall_err;
  assign busy      = (r_state != ST_IDLE) || (r_buf_cnt != 2'd0);

  // Next-state decode; a request, once raised, is held until acknowledged.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable && !empty && (r_buf_cnt < 2'd2)) w_state_nxt = ST_REQ;
      ST_REQ:  if (pop_ack) w_state_nxt = ST_CAPT;
      ST_CAPT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, registered pop_req, buffer bookkeeping, watchdog and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pop_req   <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_buf_cnt   <= 2'd0;
      r_wait_cnt  <= '0;
      r_stall_err <= 1'b0;
      r_pop_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pop_req <= (w_state_nxt == ST_REQ);

      if (w_buf_wr) r_wr_ptr <= ~r_wr_ptr;
      if (w_buf_rd) r_rd_ptr <= ~r_rd_ptr;
      case ({w_buf_wr, w_buf_rd})
        2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase

      if (w_enter_req) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ST_REQ) && !pop_ack) begin
        if (r_wait_cnt != WAIT_W'(STALL_LIMIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == WAIT_W'(STALL_LIMIT - 1)) r_stall_err <= 1'b1;
      end

      if (w_pop_hsk && (r_pop_count != '1)) r_pop_count <= r_pop_count + 1'b1;
    end
  end

  // Buffer storage: capture FIFO read data at the tail during CAPT.
  always_ff @(posedge clk) begin
    if (w_buf_wr) r_buf[r_wr_ptr] <= data_out;
  end

endmodule

// File: tb/tb_fifo_pop_agent.sv
// Bench for fifo_pop_agent: a FIFO model feeds words and acks, every popped
// word is queued as expected output, and a monitor checks delivery order and
// the pop counter. Directed sequences cover latency, backpressure, request
// stability, watchdog and reset; a random phase follows.
module tb_fifo_pop_agent;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        empty;
  logic        pop_req;
  logic        pop_ack;
  logic [7:0]  data_out;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] pop_count;
  logic        stall_err;
  logic        busy;

  int          total = 0;
  int          bad   = 0;
  int          model_cnt = 0;
  int          fifo_n = 0;
  int          ack_mode = 0;   // 0: never ack, 1: ack each request, 2: random ack
  logic        force_empty = 1'b0;
  logic [7:0]  fifo_q [$];
  logic [7:0]  exp_q  [$];
  logic        hsk_s;
  logic [7:0]  word_s;

  fifo_pop_agent #(.WIDTH(8), .STALL_LIMIT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty),
    .pop_req(pop_req), .pop_ack(pop_ack), .data_out(data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .pop_count(pop_count), .stall_err(stall_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (fifo_n == 0) || force_empty;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    fifo_n++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!pop_req && n < budget) begin
      tick();
      n++;
    end
    check("wait_req_timeout", 32'(pop_req), 32'd1);
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (32'(pop_count) != target && n < budget) begin
      tick();
      n++;
    end
    check("wait_count_timeout", 32'(pop_count), target);
  endtask

  // FIFO model: on a pop handshake it presents the next word the cycle after
  // and records it as the next expected downstream word.
  always @(posedge clk) begin
    hsk_s = pop_req && pop_ack && !reset;
    #1;
    if (hsk_s) begin
      if (fifo_q.size() > 0) begin
        word_s = fifo_q.pop_front();
        fifo_n--;
      end else begin
        word_s = 8'($urandom);
      end
      data_out = word_s;
      exp_q.push_back(word_s);
      model_cnt++;
    end else begin
      data_out = 8'($urandom);
    end
    case (ack_mode)
      1:       pop_ack = pop_req;
      2:       pop_ack = ($urandom_range(0, 2) == 0);
      default: pop_ack = 1'b0;
    endcase
  end

  // Monitor: every accepted downstream word must be the oldest popped word.
  always @(negedge clk) begin
    if (!reset) begin
      check("pop_count", 32'(pop_count), model_cnt);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        else                   check("order", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int base;
    int req_cycles;
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0; pop_ack = 1'b0; data_out = 8'h00;
    do_reset();

    // Reset state
    check("rst_pop_req", 32'(pop_req), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_pop_count", 32'(pop_count), 0);
    check("rst_stall_err", 32'(stall_err), 0);
    check("rst_busy", 32'(busy), 0);

    // Single pop with immediate ack
    enable = 1'b1; m_ready = 1'b0; ack_mode = 1; push(8'hA5);
    tick(); check("single_req_on", 32'(pop_req), 1);
    tick(); check("single_req_off", 32'(pop_req), 0);
    check("single_valid_early", 32'(m_valid), 0);
    tick(); check("single_valid", 32'(m_valid), 1);
    check("single_data", 32'(m_data), 32'hA5);
    check("single_count", 32'(pop_count), 1);
    m_ready = 1'b1;
    tick(); check("single_drained", 32'(m_valid), 0);

    // Backpressure: only two words fit
    m_ready = 1'b0; base = model_cnt; req_cycles = 0;
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pop_req) req_cycles++;
    end
    check("bp_req_cycles", req_cycles, 2);
    check("bp_count", 32'(pop_count), base + 2);
    check("bp_no_req", 32'(pop_req), 0);
    check("bp_head", 32'(m_data), 32'h11);
    check("bp_busy", 32'(busy), 1);
    m_ready = 1'b1;
    repeat (15) tick();
    check("bp_count_final", 32'(pop_count), base + 3);
    check("bp_all_delivered", exp_q.size(), 0);
    check("bp_valid_off", 32'(m_valid), 0);

    // Request stability while empty/enable toggle
    ack_mode = 0; base = model_cnt; push(8'h44);
    wait_req(10);
    for (int i = 0; i < 5; i++) begin
      force_empty = (i % 2 == 0);
      enable      = (i % 2 != 0);
      tick();
      check("stable_req", 32'(pop_req), 1);
    end
    force_empty = 1'b0; enable = 1'b0; ack_mode = 1;
    repeat (6) tick();
    check("stable_count", 32'(pop_count), base + 1);
    check("stable_delivered", exp_q.size(), 0);
    check("stable_no_stall", 32'(stall_err), 0);

    // Watchdog
    ack_mode = 0; enable = 1'b1; base = model_cnt; push(8'h55);
    wait_req(10);
    check("wd_first", 32'(stall_err), 0);
    repeat (15) tick();
    check("wd_cycle16", 32'(stall_err), 0);
    tick();
    check("wd_cycle17", 32'(stall_err), 1);
    check("wd_req_held", 32'(pop_req), 1);
    ack_mode = 1; enable = 1'b0;
    repeat (6) tick();
    check("wd_sticky", 32'(stall_err), 1);
    check("wd_count", 32'(pop_count), base + 1);
    do_reset();
    check("wd_cleared", 32'(stall_err), 0);

    // Simultaneous write and read with one word buffered
    m_ready = 1'b0; enable = 1'b1; ack_mode = 1;
    push(8'h66); push(8'h77);
    wait_count(2, 20);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("simul_valid", 32'(m_valid), 1);
    check("simul_head", 32'(m_data), 32'h77);
    m_ready = 1'b1;
    tick();
    check("simul_one_left", 32'(m_valid), 0);
    check("simul_delivered", exp_q.size(), 0);

    // Reset during a stalled request with a word buffered
    m_ready = 1'b0; ack_mode = 1; base = model_cnt;
    push(8'h88); push(8'h99);
    wait_count(base + 1, 20);
    ack_mode = 0;
    repeat (20) tick();
    check("mid_req_pre", 32'(pop_req), 1);
    check("mid_valid_pre", 32'(m_valid), 1);
    check("mid_stall_pre", 32'(stall_err), 1);
    do_reset();
    check("mid_pop_req", 32'(pop_req), 0);
    check("mid_m_valid", 32'(m_valid), 0);
    check("mid_m_data", 32'(m_data), 0);
    check("mid_pop_count", 32'(pop_count), 0);
    check("mid_stall_err", 32'(stall_err), 0);
    check("mid_busy", 32'(busy), 0);

    // Random traffic, including acks outside REQ
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      m_ready     = ($urandom_range(0, 2) != 0);
      force_empty = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) push(8'($urandom));
      tick();
    end
    ack_mode = 1; m_ready = 1'b1; enable = 1'b1; force_empty = 1'b0;
    begin
      int n = 0;
      while ((fifo_n != 0 || exp_q.size() != 0 || busy) && n < 5000) begin
        tick();
        n++;
      end
    end
    check("rand_fifo_drained", fifo_n, 0);
    check("rand_all_delivered", exp_q.size(), 0);
    check("rand_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
